// File: rtl/bcd_divider_long.sv
// Digit-serial restoring BCD long divider.
// One quotient digit is produced per SHIFT/SUB pass: the next dividend
// digit is shifted into the partial remainder, and the divisor is
// subtracted repeatedly until the partial remainder drops below it.
module bcd_divider_long #(
    parameter int DIGITS = 4,
    localparam int W     = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    // The partial remainder carries one extra digit: remainder*10 + digit
    // can reach 10^(DIGITS+1)-1.
    localparam int PW = W + 4;

    typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} state_t;

    state_t         state_reg;
    logic [W-1:0]   dvd_reg;
    logic [W-1:0]   dvs_reg;
    logic [PW-1:0]  pr_reg;
    logic [3:0]     cnt_reg;
    logic [W-1:0]   quotient_reg;
    logic [W-1:0]   remainder_reg;
    logic           done_reg;
    logic           dbz_reg;

    // BCD subtract pr_reg - divisor, one digit per stage with borrow ripple.
    logic [PW-1:0]  dvs_ext;
    logic [PW-1:0]  diff;
    logic [DIGITS+1:0] borrow;
    logic           pr_ge_dvs;

    assign dvs_ext   = {4'b0000, dvs_reg};
    assign borrow[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi <= DIGITS; gi++) begin : g_bcd_sub
            logic [5:0] raw;
            // Binary nibble difference; a negative result wraps and is
            // corrected by adding 10 while a borrow is passed upward.
            assign raw = {2'b00, pr_reg[4*gi +: 4]} - {2'b00, dvs_ext[4*gi +: 4]}
                       - {5'b00000, borrow[gi]};
            assign diff[4*gi +: 4] = raw[5] ? (raw[3:0] + 4'd10) : raw[3:0];
            assign borrow[gi+1]    = raw[5];
        end
    endgenerate

    // No borrow out of the top digit means the partial remainder is >= divisor.
    assign pr_ge_dvs = ~borrow[DIGITS+1];

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign busy        = (state_reg != IDLE);

    // Division control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            pr_reg        <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient_reg  <= '0;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            dvd_reg      <= dividend;
                            dvs_reg      <= divisor;
                            quotient_reg <= '0;
                            pr_reg       <= '0;
                            dbz_reg      <= 1'b0;
                            cnt_reg      <= 4'(DIGITS - 1);
                            state_reg    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    pr_reg       <= {pr_reg[PW-5:0], dvd_reg[W-1 -: 4]};
                    dvd_reg      <= {dvd_reg[W-5:0], 4'b0000};
                    quotient_reg <= {quotient_reg[W-5:0], 4'b0000};
                    state_reg    <= SUB;
                end
                SUB: begin
                    // The digit cap only matters for non-BCD operands; it
                    // bounds each digit pass so the operation cannot lock up.
                    if (pr_ge_dvs && quotient_reg[3:0] != 4'd9) begin
                        pr_reg            <= diff;
                        quotient_reg[3:0] <= quotient_reg[3:0] + 4'd1;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg   <= cnt_reg - 4'd1;
                        state_reg <= SHIFT;
                    end else begin
                        remainder_reg <= pr_reg[W-1:0];
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_divider_long.sv
// Directed testbench for bcd_divider_long (DIGITS=4 and DIGITS=6 instances).
module tb_bcd_divider_long;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [15:0] dividend, divisor, quotient, remainder;
    logic        busy, done, div_by_zero;

    logic        start6;
    logic [23:0] dividend6, divisor6, quotient6, remainder6;
    logic        busy6, done6, div_by_zero6;

    int n_vec = 0;
    int n_err = 0;

    bcd_divider_long #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    bcd_divider_long #(.DIGITS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6),
        .dividend(dividend6), .divisor(divisor6),
        .quotient(quotient6), .remainder(remainder6),
        .busy(busy6), .done(done6), .div_by_zero(div_by_zero6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a DIGITS=4 division, optionally poke start while busy at cycle
    // poke (0 = never), then check latency, results, busy and the done pulse.
    task automatic run4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input int elat, input int poke,
                        input string tag);
        int  lat;
        bit  busy_ok;
        lat     = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hffff;
        divisor  = 16'hffff;
        for (int k = 1; k <= 120; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (k == poke) begin
                start    = 1'b1;
                dividend = 16'h9999;
                divisor  = 16'h0003;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        $display("%s: %h/%h -> q=%h r=%h dbz=%b lat=%0d", tag, a, b, quotient, remainder, div_by_zero, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_width"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_hold_r"}, 32'(remainder), 32'(er));
    endtask

    initial begin
        int  lat6;
        bit  seen_done;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        start6    = 1'b0;
        dividend6 = '0;
        divisor6  = '0;
        #12;
        chk("reset_q", 32'(quotient), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run4(16'h1234, 16'h0056, 16'h0022, 16'h0002, 1'b0, 13, 0, "d1234_56");
        run4(16'h9999, 16'h0001, 16'h9999, 16'h0000, 1'b0, 45, 0, "d9999_1");
        run4(16'h0005, 16'h0000, 16'h0000, 16'h0005, 1'b1, 1, 0, "d5_0");
        run4(16'h0007, 16'h0009, 16'h0000, 16'h0007, 1'b0, 9, 3, "d7_9_poke");

        // start held high through DONE: re-accepted on the first IDLE cycle.
        @(negedge clk);
        dividend = 16'h0005;
        divisor  = 16'h0000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        chk("held_done1", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        chk("held_idle_done", 32'(done), 32'd0);
        chk("held_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("held_done2", 32'(done), 32'd1);
        start = 1'b0;
        @(posedge clk);
        #1;
        $display("held_start: second done observed, back to idle busy=%b", busy);

        // Reset mid-operation: outputs clear before any clock edge, no done after.
        @(negedge clk);
        dividend = 16'h9999;
        divisor  = 16'h0001;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        chk("pre_reset_q_nonzero", 32'(quotient != 16'h0000), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", 32'(quotient), 32'd0);
        chk("async_rst_r", 32'(remainder), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        $display("reset_abort: activity after release=%b", seen_done);
        chk("reset_no_done", 32'(seen_done), 32'd0);

        run4(16'h0100, 16'h0007, 16'h0014, 16'h0002, 1'b0, 14, 0, "d100_7");

        // DIGITS=6 instance.
        lat6 = -1;
        @(negedge clk);
        dividend6 = 24'h999999;
        divisor6  = 24'h000999;
        start6    = 1'b1;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            if (done6) begin
                lat6 = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        $display("d6_999999_999: q=%h r=%h lat=%0d", quotient6, remainder6, lat6);
        chk("d6_latency", 32'(lat6), 32'd15);
        chk("d6_quotient", 32'(quotient6), 32'h001001);
        chk("d6_remainder", 32'(remainder6), 32'h000000);
        chk("d6_dbz", 32'(div_by_zero6), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
